// File: rtl/zmod_dac_pkg.sv
// Shared types and constants for the Zmod DAC driver: FSM encodings, SPI instruction
// layout and the boot configuration table.
package zmod_dac_pkg;

    typedef enum logic [1:0] {
        BOOT_LOAD = 2'd0,
        SHIFT     = 2'd1,
        GAP       = 2'd2,
        IDLE      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_LEAD  = 2'd0,
        PH_CLOCK = 2'd1,
        PH_TAIL  = 2'd2
    } spi_phase_t;

    // Instruction byte: {rw, 2'b00, addr[4:0]}, rw = 0 for a write.
    localparam int INSTR_RW_BIT = 7;
    localparam int INSTR_ADDR_W = 5;

    localparam logic [15:0] CFG_TABLE [16] = '{
        16'h0100,   // power-down register: all blocks on
        16'h0280,   // data control: two's-complement input format
        16'h0834,   // I DAC gain
        16'h0CB6,   // Q DAC gain
        16'h1400,   // clock mode
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/zmod_dac_spi_master.sv
// 16-bit SPI write master: SCK idles high, SDO launched on falling edges, CS framed
// one half-period around the clock burst.
module zmod_dac_spi_master
    import zmod_dac_pkg::*;
#(
    parameter int SPI_DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] word,
    output logic        busy,
    output logic        done,
    output logic        sck,
    output logic        cs,
    output logic        sdo
);

    localparam int               DIV_W    = $clog2(SPI_DIV);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SPI_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg;
    spi_phase_t       phase;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b1;
            cs      <= 1'b1;
            sdo     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 4'd15;
            shreg   <= '0;
            phase   <= PH_LEAD;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    cs      <= 1'b0;
                    shreg   <= word;
                    bit_cnt <= 4'd15;
                    div_cnt <= DIV_LOAD;
                    phase   <= PH_LEAD;
                end
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end else begin
                div_cnt <= DIV_LOAD;
                unique case (phase)
                    PH_LEAD: begin
                        sck   <= 1'b0;
                        sdo   <= shreg[15];
                        shreg <= shreg << 1;
                        phase <= PH_CLOCK;
                    end
                    PH_CLOCK: begin
                        if (!sck) begin
                            // rising edge: the DAC samples here; the last one closes the word
                            sck <= 1'b1;
                            if (bit_cnt == 4'd0) phase   <= PH_TAIL;
                            else                 bit_cnt <= bit_cnt - 4'd1;
                        end else begin
                            sck   <= 1'b0;
                            sdo   <= shreg[15];
                            shreg <= shreg << 1;
                        end
                    end
                    PH_TAIL: begin
                        cs   <= 1'b1;
                        sdo  <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    default: phase <= PH_LEAD;
                endcase
            end
        end
    end

endmodule

// File: rtl/zmod_dac_driver_v2_0.sv
// Zmod DAC driver: boot-time SPI configuration, runtime SPI writes and the DDR I/Q bus.
// state     | meaning
// BOOT_LOAD | fetch CFG_TABLE[idx] and start the SPI master
// SHIFT     | word on the wire, wait for SPI done
// GAP       | CS held high between words
// IDLE      | configuration done, runtime write port open
module zmod_dac_driver_v2_0
    import zmod_dac_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int SPI_DIV = 4,
    parameter int N_CFG   = 4,
    parameter int SWAP_IQ = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] is_data_i,
    input  logic [DATA_W-1:0] is_data_q,
    input  logic              i_run,
    input  logic              i_wr_valid,
    input  logic [15:0]       i16_wr_word,
    output logic              o_wr_ready,
    output logic              o_cfg_done,
    output logic [13:0]       os14_data,
    output logic              or_sck,
    output logic              or_cs,
    output logic              o_sdo
);

    // GAP length makes CS high for exactly two half-periods, counting the
    // done/start pipeline cycles on either side of it.
    localparam int               GAP_W    = $clog2(2 * SPI_DIV);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(2 * SPI_DIV - 4);
    localparam logic [3:0]       LAST_IDX = 4'(N_CFG - 1);
    localparam int               PAD      = 14 - DATA_W;

    state_t             state;
    logic [3:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic               spi_start;
    logic [15:0]        spi_word;
    logic               spi_busy;
    logic               spi_done;
    logic               streaming;
    logic [13:0]        ch_i, ch_q, ddr_hi, ddr_lo;

    zmod_dac_spi_master #(.SPI_DIV(SPI_DIV)) u_spi (
        .clk   (clk),
        .rstn  (rstn),
        .start (spi_start),
        .word  (spi_word),
        .busy  (spi_busy),
        .done  (spi_done),
        .sck   (or_sck),
        .cs    (or_cs),
        .sdo   (o_sdo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= BOOT_LOAD;
            idx        <= 4'd0;
            gap_cnt    <= '0;
            spi_start  <= 1'b0;
            spi_word   <= '0;
            o_wr_ready <= 1'b0;
            o_cfg_done <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            unique case (state)
                BOOT_LOAD: begin
                    if (!spi_busy) begin
                        spi_word  <= CFG_TABLE[idx];
                        spi_start <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (spi_done) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (idx < LAST_IDX) begin
                        idx   <= idx + 4'd1;
                        state <= BOOT_LOAD;
                    end else begin
                        // idx parks at the last entry, so runtime writes also come back here
                        o_cfg_done <= 1'b1;
                        o_wr_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                IDLE: begin
                    if (i_wr_valid && o_wr_ready) begin
                        spi_word   <= i16_wr_word;
                        spi_start  <= 1'b1;
                        o_wr_ready <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                default: state <= BOOT_LOAD;
            endcase
        end
    end

    assign streaming = i_run && o_cfg_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_i   <= '0;
            ch_q   <= '0;
            ddr_hi <= '0;
            ddr_lo <= '0;
        end else begin
            ch_i   <= streaming ? (14'(is_data_i) << PAD) : 14'd0;
            ch_q   <= streaming ? (14'(is_data_q) << PAD) : 14'd0;
            ddr_hi <= (SWAP_IQ != 0) ? ch_q : ch_i;
            ddr_lo <= (SWAP_IQ != 0) ? ch_i : ch_q;
        end
    end

    // Both halves are launched together; the output mux places them in the clk phases.
    assign os14_data = clk ? ddr_hi : ddr_lo;

endmodule

// File: tb/tb_zmod_dac_driver_v2_0.sv
// Scoreboard bench for zmod_dac_driver_v2_0: SPI frames and DDR samples are checked
// against queues filled by the stimulus processes.
module tb_zmod_dac_driver_v2_0;

    localparam int DW      = 12;
    localparam int SPI_DIV = 4;
    localparam int N_CFG   = 4;
    localparam logic [15:0] TBL [4] = '{16'h0100, 16'h0280, 16'h0834, 16'h0CB6};

    typedef struct {
        int          due;
        logic [13:0] hi, lo, hi_sw, lo_sw;
    } samp_t;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] is_data_i, is_data_q;
    logic          i_run;
    logic          i_wr_valid;
    logic [15:0]   i16_wr_word;
    logic          o_wr_ready, o_cfg_done, or_sck, or_cs, o_sdo;
    logic [13:0]   os14_data;
    logic          ready_sw, done_sw, sck_sw, cs_sw, sdo_sw;
    logic [13:0]   data_sw;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic          stream_en = 1'b0;
    logic [15:0]   exp_words[$];
    samp_t         exp_data[$];
    int            frames_seen = 0;
    logic          in_frame = 1'b0;
    int            nbits = 0;

    zmod_dac_driver_v2_0 #(.DATA_W(DW), .SPI_DIV(SPI_DIV), .N_CFG(N_CFG), .SWAP_IQ(0)) dut (
        .clk(clk), .rstn(rstn), .is_data_i(is_data_i), .is_data_q(is_data_q), .i_run(i_run),
        .i_wr_valid(i_wr_valid), .i16_wr_word(i16_wr_word), .o_wr_ready(o_wr_ready),
        .o_cfg_done(o_cfg_done), .os14_data(os14_data), .or_sck(or_sck), .or_cs(or_cs), .o_sdo(o_sdo)
    );

    zmod_dac_driver_v2_0 #(.DATA_W(DW), .SPI_DIV(SPI_DIV), .N_CFG(N_CFG), .SWAP_IQ(1)) dut_sw (
        .clk(clk), .rstn(rstn), .is_data_i(is_data_i), .is_data_q(is_data_q), .i_run(i_run),
        .i_wr_valid(i_wr_valid), .i16_wr_word(i16_wr_word), .o_wr_ready(ready_sw),
        .o_cfg_done(done_sw), .os14_data(data_sw), .or_sck(sck_sw), .or_cs(cs_sw), .o_sdo(sdo_sw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Left-justify a DW-bit sample into the 14-bit bus, zero when not streaming.
    function automatic logic [13:0] ljust(input logic run, input logic [DW-1:0] s);
        int v;
        v = run ? int'(s) * (1 << (14 - DW)) : 0;
        return 14'(v % 16384);
    endfunction

    // Data stimulus: owns i_run and the sample inputs; pushes expected bus halves.
    initial begin
        int    k;
        samp_t e;
        k = 0;
        i_run = 1'b1;
        is_data_i = 12'h123;
        is_data_q = 12'h456;
        forever begin
            @(negedge clk);
            if (stream_en) begin
                if (k < 3) begin
                    i_run = 1'b1; is_data_i = 12'h7FF; is_data_q = 12'h800;
                end else begin
                    if (k < 6)                            i_run = 1'b0;
                    else if ($urandom_range(0, 7) == 0)   i_run = ~i_run;
                    is_data_i = DW'($urandom_range(0, 4095));
                    is_data_q = DW'($urandom_range(0, 4095));
                end
                k++;
                e.due   = cyc + 2;
                e.hi    = ljust(i_run, is_data_i);
                e.lo    = ljust(i_run, is_data_q);
                e.hi_sw = e.lo;
                e.lo_sw = e.hi;
                exp_data.push_back(e);
            end
        end
    end

    // Data monitor: sample high and low phases, compare against the due entry.
    initial begin
        logic [13:0] hi, lo, hi_sw, lo_sw;
        samp_t       e;
        forever begin
            @(posedge clk); #1;
            hi = os14_data; hi_sw = data_sw;
            @(negedge clk); #1;
            lo = os14_data; lo_sw = data_sw;
            while (exp_data.size() > 0 && exp_data[0].due < cyc) begin
                e = exp_data.pop_front();
                chk("data_missed", cyc, e.due);
            end
            if (exp_data.size() > 0 && exp_data[0].due == cyc) begin
                e = exp_data.pop_front();
                chk("bus_rise", hi, e.hi);
                chk("bus_fall", lo, e.lo);
                chk("bus_rise_swap", hi_sw, e.hi_sw);
                chk("bus_fall_swap", lo_sw, e.lo_sw);
            end
        end
    end

    // SPI frame monitor: decodes CS/SCK/SDO and checks framing timing and payload.
    initial begin
        logic        prev_cs, prev_sck, have_rise;
        logic [15:0] rx;
        int          t_cs_fall, t_cs_rise, t_rise, nfalls;
        prev_cs = 1'b1; prev_sck = 1'b1; have_rise = 1'b0; rx = '0;
        t_cs_fall = 0; t_cs_rise = 0; t_rise = 0; nfalls = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                in_frame = 1'b0; nbits = 0; frames_seen = 0; have_rise = 1'b0;
            end else begin
                if (prev_cs && !or_cs) begin
                    if (have_rise) chk("cs_gap_min", 32'((cyc - t_cs_rise) >= 2 * SPI_DIV), 1);
                    in_frame = 1'b1; nbits = 0; nfalls = 0; rx = '0; t_cs_fall = cyc;
                end
                if (in_frame && prev_sck && !or_sck) begin
                    if (nfalls == 0) chk("cs_lead", cyc - t_cs_fall, SPI_DIV);
                    nfalls++;
                end
                if (in_frame && !prev_sck && or_sck) begin
                    rx = {rx[14:0], o_sdo};
                    if (nbits > 0) chk("sck_period", cyc - t_rise, 2 * SPI_DIV);
                    t_rise = cyc;
                    nbits++;
                end
                if (in_frame && !prev_cs && or_cs) begin
                    chk("frame_bits", nbits, 16);
                    chk("cs_tail", cyc - t_rise, SPI_DIV);
                    if (exp_words.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL frame_unexpected: got word 0x%04h, expected no frame", rx);
                    end else begin
                        chk("frame_word", rx, exp_words.pop_front());
                    end
                    frames_seen++;
                    in_frame = 1'b0; have_rise = 1'b1; t_cs_rise = cyc;
                end
            end
            prev_cs = or_cs; prev_sck = or_sck;
        end
    end

    task automatic do_write(input logic [15:0] w);
        int t, f0;
        exp_words.push_back(w);
        @(negedge clk);
        i16_wr_word = w;
        i_wr_valid  = 1'b1;
        t = 0;
        while (!o_wr_ready && t < 3000) begin @(negedge clk); t++; end
        chk("wr_accept_timeout", 32'(t < 3000), 1);
        f0 = frames_seen;
        @(posedge clk); #1;
        chk("wr_ready_drop", o_wr_ready, 0);
        i_wr_valid = 1'b0;
        t = 0;
        while (!o_wr_ready && t < 3000) begin @(negedge clk); t++; end
        chk("wr_ready_return_timeout", 32'(t < 3000), 1);
        chk("wr_frame_before_ready", frames_seen, f0 + 1);
    endtask

    initial begin
        int          t;
        logic        prev_done;
        logic [15:0] w1;
        rstn = 1'b1; i_wr_valid = 1'b0; i16_wr_word = '0;
        #2 rstn = 1'b0;
        #21;
        chk("rst_cs", or_cs, 1);
        chk("rst_sck", or_sck, 1);
        chk("rst_sdo", o_sdo, 0);
        chk("rst_ready", o_wr_ready, 0);
        chk("rst_cfg_done", o_cfg_done, 0);
        chk("rst_bus", os14_data, 0);
        chk("rst_swap_outs", {27'd0, cs_sw, sck_sw, sdo_sw, ready_sw, done_sw}, 32'b11000);

        for (int i = 0; i < N_CFG; i++) exp_words.push_back(TBL[i]);
        @(negedge clk) rstn = 1'b1;

        repeat (30) @(posedge clk);
        #1;
        chk("boot_bus_rise_zero", os14_data, 0);
        chk("boot_ready_low", o_wr_ready, 0);
        @(negedge clk); #1;
        chk("boot_bus_fall_zero", os14_data, 0);
        chk("boot_swap_bus_zero", data_sw, 0);

        // Abort the second boot word while bit 7 is on the wire.
        t = 0;
        while (!(frames_seen == 1 && in_frame && nbits == 8) && t < 2000) begin
            @(negedge clk); #1; t++;
        end
        chk("reach_bit7_timeout", 32'(t < 2000), 1);
        repeat (SPI_DIV) @(negedge clk);
        chk("bit7_cs_low", or_cs, 0);
        chk("bit7_sck_low", or_sck, 0);
        chk("bit7_sdo", o_sdo, TBL[1][7]);
        #2 rstn = 1'b0;
        #1;
        chk("abort_cs", or_cs, 1);
        chk("abort_sck", or_sck, 1);
        chk("abort_sdo", o_sdo, 0);
        chk("abort_ready", o_wr_ready, 0);
        repeat (3) @(negedge clk);

        // Restart: full table again, with a write request held from release.
        exp_words.delete();
        for (int i = 0; i < N_CFG; i++) exp_words.push_back(TBL[i]);
        w1 = 16'($urandom());
        exp_words.push_back(w1);
        i16_wr_word = w1;
        i_wr_valid  = 1'b1;
        @(negedge clk) rstn = 1'b1;

        prev_done = 1'b0;
        t = 0;
        while (!o_wr_ready && t < 4000) begin
            prev_done = o_cfg_done;
            @(negedge clk); t++;
        end
        chk("boot_timeout", 32'(t < 4000), 1);
        chk("boot_done_with_ready", o_cfg_done, 1);
        chk("boot_no_early_done", prev_done, 0);
        chk("boot_frame_count", frames_seen, N_CFG);
        @(posedge clk); #1;
        chk("held_wr_ready_drop", o_wr_ready, 0);
        chk("cfg_done_sticky", o_cfg_done, 1);
        i_wr_valid = 1'b0;
        t = 0;
        while (!o_wr_ready && t < 3000) begin @(negedge clk); t++; end
        chk("held_wr_return_timeout", 32'(t < 3000), 1);
        chk("held_wr_frame_count", frames_seen, N_CFG + 1);

        stream_en = 1'b1;
        do_write(16'h0A55);
        for (int i = 0; i < 4; i++) do_write(16'($urandom()));
        stream_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("cfg_done_end", o_cfg_done, 1);
        chk("data_queue_drained", exp_data.size(), 0);
        chk("frame_queue_drained", exp_words.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
